// File: rtl/rf_dump_reader.sv
// rtl/rf_dump_reader.sv - register file dump engine with valid/ready output and running checksum
//
// Sweeps registers first_i..last_i through one RF read port and presents each
// word on a valid/ready stream. It also accumulates a mod-2^DW checksum of the
// accepted words.
//
// Ports:
//   clk, rst_n           clock; asynchronous reset, asserted when rst_n=1
//   start_i, first_i,    dump request and inclusive register range,
//   last_i               sampled only while idle
//   abort_i              cancel a dump in progress
//   rf_ra_o, rf_rd_i     RF read address and same-cycle read data
//   dump_valid_o, dump_ready_i, dump_addr_o, dump_data_o, dump_last_o
//                        output word stream
//   busy_o               engine not idle
//   done_o               one-cycle pulse after the final word is accepted
//   err_o                one-cycle pulse when the requested range is reversed
//   checksum_o           sum of the words accepted in the current/last dump
module rf_dump_reader #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start_i,
    input  logic          abort_i,
    input  logic [AW-1:0] first_i,
    input  logic [AW-1:0] last_i,
    output logic [AW-1:0] rf_ra_o,
    input  logic [DW-1:0] rf_rd_i,
    output logic          dump_valid_o,
    input  logic          dump_ready_i,
    output logic [AW-1:0] dump_addr_o,
    output logic [DW-1:0] dump_data_o,
    output logic          dump_last_o,
    output logic          busy_o,
    output logic          done_o,
    output logic          err_o,
    output logic [DW-1:0] checksum_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t        state;
    logic [AW-1:0] ptr;
    logic [AW-1:0] last_q;
    logic          handshake;

    // The RF port belongs to decode whenever the engine is not reading, so the
    // address is parked at 0 outside LOAD/SEND.
    assign rf_ra_o   = (state == LOAD || state == SEND) ? ptr : '0;
    assign busy_o    = (state != IDLE);
    assign handshake = dump_valid_o & dump_ready_i;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state        <= IDLE;
            ptr          <= '0;
            last_q       <= '0;
            dump_valid_o <= 1'b0;
            dump_addr_o  <= '0;
            dump_data_o  <= '0;
            dump_last_o  <= 1'b0;
            done_o       <= 1'b0;
            err_o        <= 1'b0;
            checksum_o   <= '0;
        end else begin
            done_o <= 1'b0;
            err_o  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        if (first_i <= last_i) begin
                            ptr        <= first_i;
                            last_q     <= last_i;
                            checksum_o <= '0;
                            state      <= LOAD;
                        end else begin
                            err_o <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (abort_i) begin
                        state <= IDLE;
                    end else begin
                        // Snapshot the word now; later RF writes must not
                        // change what is being presented.
                        dump_data_o  <= rf_rd_i;
                        dump_addr_o  <= ptr;
                        dump_last_o  <= (ptr == last_q);
                        dump_valid_o <= 1'b1;
                        state        <= SEND;
                    end
                end
                SEND: begin
                    // An accepted word always counts, even if abort arrives
                    // in the same cycle.
                    if (handshake) begin
                        checksum_o   <= checksum_o + dump_data_o;
                        dump_valid_o <= 1'b0;
                    end
                    if (abort_i) begin
                        dump_valid_o <= 1'b0;
                        state        <= IDLE;
                    end else if (handshake) begin
                        // Stop on last_q rather than incrementing, so a range
                        // ending at the top register never wraps to 0.
                        if (ptr == last_q) begin
                            done_o <= 1'b1;
                            state  <= DONE;
                        end else begin
                            ptr   <= ptr + 1'b1;
                            state <= LOAD;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rf_dump_reader.sv
// tb/tb_rf_dump_reader.sv - self-checking bench for rf_dump_reader
module tb_rf_dump_reader;
    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start_i = 1'b0;
    logic          abort_i = 1'b0;
    logic [AW-1:0] first_i = '0;
    logic [AW-1:0] last_i = '0;
    logic [AW-1:0] rf_ra_o;
    logic [DW-1:0] rf_rd_i;
    logic          dump_valid_o;
    logic          dump_ready_i = 1'b1;
    logic [AW-1:0] dump_addr_o;
    logic [DW-1:0] dump_data_o;
    logic          dump_last_o;
    logic          busy_o;
    logic          done_o;
    logic          err_o;
    logic [DW-1:0] checksum_o;

    logic [DW-1:0] rf [32];
    assign rf_rd_i = rf[rf_ra_o];

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          last;
    } word_t;

    word_t exp_q[$];
    int    checks = 0;
    int    errors = 0;

    always #5 clk = ~clk;

    rf_dump_reader #(.DW(DW), .AW(AW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start_i),
        .abort_i      (abort_i),
        .first_i      (first_i),
        .last_i       (last_i),
        .rf_ra_o      (rf_ra_o),
        .rf_rd_i      (rf_rd_i),
        .dump_valid_o (dump_valid_o),
        .dump_ready_i (dump_ready_i),
        .dump_addr_o  (dump_addr_o),
        .dump_data_o  (dump_data_o),
        .dump_last_o  (dump_last_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_o        (err_o),
        .checksum_o   (checksum_o)
    );

    task automatic start_dump(input logic [AW-1:0] f, input logic [AW-1:0] l);
        @(posedge clk); #1;
        start_i = 1'b1;
        first_i = f;
        last_i  = l;
    endtask

    // One complete dump of f..l; each word is stalled 'stall' cycles. With
    // ovw set, R4 is rewritten while word 4 is held.
    task automatic test_dump(input string name, input int f, input int l,
                             input int stall, input bit ovw);
        word_t         w;
        logic [DW-1:0] sum = '0;
        logic [DW-1:0] hd = '0;
        logic [AW-1:0] ha = '0;
        bit            hv = 0;
        bit            seen_done = 0;
        int            words = 0;
        int            hs_cyc = -10;
        int            first_v = -1;
        int            held = 0;
        exp_q.delete();
        for (int i = f; i <= l; i++) begin
            w.addr = i[AW-1:0];
            w.data = rf[i];
            w.last = (i == l);
            exp_q.push_back(w);
            sum = sum + rf[i];
        end
        start_dump(f[AW-1:0], l[AW-1:0]);
        for (int cyc = 1; cyc <= 400 && !seen_done; cyc++) begin
            @(posedge clk); #1;
            start_i = 1'b0;
            if (dump_valid_o && held < stall) begin
                dump_ready_i = 1'b0;
                held++;
            end else begin
                dump_ready_i = 1'b1;
            end
            if (ovw && dump_valid_o && dump_addr_o == 4 && held == 2)
                rf[4] = rf[4] ^ 32'hFFFF_0000;
            @(negedge clk);
            if (dump_valid_o && first_v < 0) first_v = cyc;
            if (dump_valid_o && hv) begin
                checks++;
                if (dump_data_o !== hd || dump_addr_o !== ha) begin
                    errors++;
                    $display("FAIL %s stall_stable: got %h@%0d required %h@%0d", name, dump_data_o, dump_addr_o, hd, ha);
                end
            end
            hv = 0;
            if (dump_valid_o && !dump_ready_i) begin
                hv = 1;
                hd = dump_data_o;
                ha = dump_addr_o;
            end
            if (dump_valid_o && dump_ready_i) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL %s extra_word: got addr %0d required none", name, dump_addr_o);
                end else begin
                    w = exp_q.pop_front();
                    if ({dump_addr_o, dump_data_o, dump_last_o} !== w) begin
                        errors++;
                        $display("FAIL %s word: got %0d/%h/%b required %0d/%h/%b", name,
                                 dump_addr_o, dump_data_o, dump_last_o, w.addr, w.data, w.last);
                    end
                end
                words++;
                hs_cyc = cyc;
                held = 0;
            end
            if (done_o) begin
                seen_done = 1;
                checks++;
                if (cyc !== hs_cyc + 1) begin
                    errors++;
                    $display("FAIL %s done_timing: got cycle %0d required %0d", name, cyc, hs_cyc + 1);
                end
            end
        end
        dump_ready_i = 1'b1;
        checks++;
        if (!seen_done) begin
            errors++;
            $display("FAIL %s done_seen: got 0 required 1 (timeout)", name);
        end
        checks++;
        if (first_v !== 2) begin
            errors++;
            $display("FAIL %s first_valid_latency: got %0d required 2", name, first_v);
        end
        checks++;
        if (words !== l - f + 1 || exp_q.size() !== 0) begin
            errors++;
            $display("FAIL %s word_count: got %0d required %0d", name, words, l - f + 1);
        end
        checks++;
        if (checksum_o !== sum) begin
            errors++;
            $display("FAIL %s checksum: got %h required %h", name, checksum_o, sum);
        end
        @(negedge clk);
        checks++;
        if (rf_ra_o !== '0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL %s idle_after: got ra=%0d busy=%b required ra=0 busy=0", name, rf_ra_o, busy_o);
        end
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({dump_valid_o, busy_o, done_o, err_o, dump_last_o} !== 5'b0 ||
            dump_data_o !== '0 || dump_addr_o !== '0 || checksum_o !== '0 || rf_ra_o !== '0) begin
            errors++;
            $display("FAIL reset_state: got valid=%b busy=%b data=%h sum=%h ra=%0d required all 0",
                     dump_valid_o, busy_o, dump_data_o, checksum_o, rf_ra_o);
        end
        @(posedge clk); #1;
        rst_n = 1'b0;
    endtask

    task automatic test_bad_range();
        logic [DW-1:0] prev = checksum_o;
        start_dump(5'd9, 5'd2);
        @(posedge clk); #1;
        start_i = 1'b0;
        @(negedge clk);
        checks++;
        if (err_o !== 1'b1 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL bad_range_err: got err=%b busy=%b required err=1 busy=0", err_o, busy_o);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (err_o !== 1'b0 || busy_o !== 1'b0 || dump_valid_o !== 1'b0 || checksum_o !== prev) begin
                errors++;
                $display("FAIL bad_range_after: got err=%b busy=%b valid=%b sum=%h required 0/0/0/%h",
                         err_o, busy_o, dump_valid_o, checksum_o, prev);
            end
        end
    endtask

    task automatic test_abort();
        word_t         w;
        bit            stalled = 0;
        bit            saw_done = 0;
        logic [DW-1:0] sum = rf[4] + rf[5];
        exp_q.delete();
        for (int i = 4; i <= 5; i++) begin
            w.addr = i[AW-1:0];
            w.data = rf[i];
            w.last = 1'b0;
            exp_q.push_back(w);
        end
        start_dump(5'd4, 5'd10);
        for (int cyc = 1; cyc <= 100 && !stalled; cyc++) begin
            @(posedge clk); #1;
            start_i = 1'b0;
            dump_ready_i = !(dump_valid_o && dump_addr_o == 6);
            @(negedge clk);
            if (done_o) saw_done = 1;
            if (dump_valid_o && dump_ready_i) begin
                checks++;
                w = exp_q.pop_front();
                if ({dump_addr_o, dump_data_o, dump_last_o} !== w) begin
                    errors++;
                    $display("FAIL abort_word: got %0d/%h required %0d/%h", dump_addr_o, dump_data_o, w.addr, w.data);
                end
            end
            if (dump_valid_o && !dump_ready_i) stalled = 1;
        end
        checks++;
        if (!stalled) begin
            errors++;
            $display("FAIL abort_stall_reached: got 0 required 1 (timeout)");
        end
        @(posedge clk); #1;
        abort_i = 1'b1;
        @(posedge clk); #1;
        abort_i = 1'b0;
        dump_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done_o) saw_done = 1;
            checks++;
            if (dump_valid_o !== 1'b0 || busy_o !== 1'b0 || checksum_o !== sum) begin
                errors++;
                $display("FAIL abort_idle: got valid=%b busy=%b sum=%h required 0/0/%h",
                         dump_valid_o, busy_o, checksum_o, sum);
            end
        end
        checks++;
        if (saw_done) begin
            errors++;
            $display("FAIL abort_no_done: got 1 required 0");
        end
    endtask

    task automatic test_reset_mid();
        bit in_send = 0;
        dump_ready_i = 1'b0;
        start_dump(5'd0, 5'd3);
        for (int cyc = 0; cyc < 20 && !in_send; cyc++) begin
            @(posedge clk); #1;
            start_i = 1'b0;
            @(negedge clk);
            if (dump_valid_o) in_send = 1;
        end
        #2;
        rst_n = 1'b1;
        #1;
        checks++;
        if ({dump_valid_o, busy_o, done_o, err_o, dump_last_o} !== 5'b0 ||
            dump_data_o !== '0 || dump_addr_o !== '0 || checksum_o !== '0 || rf_ra_o !== '0 || !in_send) begin
            errors++;
            $display("FAIL reset_mid: got valid=%b busy=%b addr=%0d data=%h sum=%h ra=%0d required all 0",
                     dump_valid_o, busy_o, dump_addr_o, dump_data_o, checksum_o, rf_ra_o);
        end
        dump_ready_i = 1'b1;
        start_i = 1'b1;
        first_i = 5'd0;
        last_i  = 5'd1;
        @(posedge clk);
        @(posedge clk); #1;
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_start_ignored: got busy=%b required 0", busy_o);
        end
        start_i = 1'b0;
        rst_n = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = i * 32'h0101_0101;
        test_reset();
        test_dump("full_dump", 0, 31, 0, 0);
        test_dump("backpressure", 3, 5, 4, 1);
        test_bad_range();
        rf[31] = 32'hDEAD_BEEF;
        test_dump("single_top", 31, 31, 0, 0);
        for (int i = 0; i < 32; i++) rf[i] = $urandom;
        rf[0] = '0;
        test_abort();
        test_dump("after_abort", 1, 2, 1, 0);
        test_reset_mid();
        test_dump("after_reset", 0, 1, 0, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
